init_load_seq: RTL and testbench
================================

# init_load_seq

Sequencer that sits directly upstream of the RAM-initialisation loader in the PFPGA. On a start request it drives the loader's `load_ram_en`, then waits for the loader's `load_ram_done` / `load_ram_error`. It applies a per-attempt timeout and a bounded retry policy, latches the loader's 288-bit CRC vector on success, and reports a single terminal pass/fail status to board-level control.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 32'd50_000_000: maximum `sys_clk` cycles per attempt while waiting for done/error.
- `MAX_RETRY`, default 3: retries allowed after the first attempt, so total attempts are `1+MAX_RETRY`. Legal range is 0..15.
- `RETRY_GAP`, default 16'd1000: cycles `load_ram_en` is held low between attempts. Minimum is 2.

Ports:
- `sys_clk`, in, 1: the single clock.
- `glbl_rst_n`, in, 1: reset; synchronous, active-low.
- `init_start`, in, 1: start request. Sampled only in IDLE, OK or FAIL.
- `load_ram_en`, out, 1: level enable to the loader, high for the whole of an attempt.
- `load_ram_done`, in, 1: loader success.
- `load_ram_error`, in, 1: loader failure.
- `load_ram_crc`, in, 288: loader CRC vector. Valid in the cycle `load_ram_done` is high.
- `load_busy`, out, 1: high in WAIT or GAP.
- `load_ok`, out, 1: high in OK.
- `load_fail`, out, 1: high in FAIL.
- `fail_cause`, out, 2: cause of the last failed attempt. 00 none, 01 loader error, 10 timeout.
- `attempt_cnt`, out, 4: index of the current or last attempt, 0-based.
- `crc_latched`, out, 288: CRC captured on success.
- `seq_state`, out, 3: FSM state code for debug. IDLE=0, WAIT=1, GAP=2, OK=3, FAIL=4.

## Operation

- FSM states are IDLE, WAIT, GAP, OK, FAIL. All outputs are registered.
- IDLE: if `init_start`=1, clear `attempt_cnt`, `fail_cause` and the timeout counter, then go to WAIT.
- WAIT: `load_ram_en`=1 and the timeout counter increments each cycle. Evaluate in this priority order:
  1. `load_ram_error`=1 ends the attempt with failure, cause 01. This applies even when `load_ram_done` is high in the same cycle.
  2. `load_ram_done`=1 latches `crc_latched` <= `load_ram_crc` and goes to OK.
  3. If the timeout counter equals `TIMEOUT_CYCLES-1`, the attempt fails with cause 10.
- Failed attempt:
  - If `attempt_cnt` < `MAX_RETRY`, go to GAP. The gap counter is cleared and `attempt_cnt` increments on entry.
  - Otherwise go to FAIL.
- GAP: `load_ram_en`=0 and `load_ram_done` / `load_ram_error` are ignored, since they are stale from the previous attempt. The gap counter increments each cycle. When it reaches `RETRY_GAP-1`, clear the timeout counter and go to WAIT.
- OK and FAIL are terminal. `crc_latched`, `fail_cause` and `attempt_cnt` hold their values.
- `init_start`=1 in OK or FAIL restarts exactly as from IDLE. On that restart `crc_latched` is not cleared; it is overwritten on the next success.
- `init_start` is ignored in WAIT and GAP.
- `fail_cause` is cleared only on a start. After a success that followed a retry, it keeps the cause of the prior failed attempt.
- `attempt_cnt` saturates logically at `MAX_RETRY` and never wraps.

## Timing

- Reset values, as in effect in the cycle after `glbl_rst_n` is sampled low:
  - state IDLE;
  - `load_ram_en`, `load_busy`, `load_ok`, `load_fail` = 0;
  - `fail_cause`=0, `attempt_cnt`=0, `crc_latched`=0, `seq_state`=0.
- Reset mid-attempt behaves identically, and drops `load_ram_en` the following cycle.
- `init_start` sampled high at cycle N gives `load_ram_en`=1 and `load_busy`=1 from N+1.
- `load_ram_done` sampled in cycle M gives `load_ok`=1, `load_ram_en`=0, `load_busy`=0 and valid `crc_latched`, all at M+1.
- `load_ram_error` sampled in cycle M gives `load_ram_en`=0 at M+1, then:
  - either `load_ram_en`=1 again at M+1+`RETRY_GAP`,
  - or `load_fail`=1 at M+1 when no retries remain.
- Timeout: with no response, WAIT lasts exactly `TIMEOUT_CYCLES` cycles per attempt, and `load_ram_en` is high for exactly that many cycles.
- Done or error arriving in the same cycle the timeout expires is not counted as a timeout: the done/error priority rules apply.

## Test plan

- Setup for all scenarios: `TIMEOUT_CYCLES`=100, `MAX_RETRY`=2, `RETRY_GAP`=8.
- Clean pass:
  - Stimulus: start at cycle 10; done at cycle 30 with crc=288'hA5…A5.
  - Required: `load_ram_en` high on cycles 11..30; `load_ok`=1 at 31; `crc_latched`=A5…A5; `attempt_cnt`=0; `fail_cause`=0.
- Error then pass:
  - Stimulus: error in attempt 0; done in attempt 1.
  - Required: `load_ram_en` low for exactly 8 cycles; `attempt_cnt`=1; `load_ok`=1; `fail_cause`=01.
  - Also: done/error pulsed during GAP must be ignored.
- All timeouts:
  - Stimulus: no response.
  - Required: three WAIT windows of 100 cycles each, separated by 8-cycle gaps; `load_fail`=1; `fail_cause`=10; `attempt_cnt`=2.
- Simultaneous done+error:
  - Stimulus: done and error in the same cycle of the final attempt.
  - Required: `load_fail`=1, `fail_cause`=01, `crc_latched` unchanged.
- Restart and reset:
  - Start again from FAIL: `attempt_cnt` goes to 0 and `load_ram_en` is high the next cycle.
  - `glbl_rst_n`=0 mid-WAIT: all outputs at reset values the next cycle.
  - `init_start` during WAIT: no effect.

Source files
------------

// File: rtl/init_load_seq.sv
// Drives the RAM-init loader with per-attempt timeout and bounded retries, then reports pass/fail.
// All outputs registered: a start or a loader response shows on the outputs one cycle after it is sampled.
module init_load_seq #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [15:0] RETRY_GAP      = 16'd1000
) (
  input  logic         sys_clk,
  input  logic         glbl_rst_n,
  input  logic         init_start,
  output logic         load_ram_en,
  input  logic         load_ram_done,
  input  logic         load_ram_error,
  input  logic [287:0] load_ram_crc,
  output logic         load_busy,
  output logic         load_ok,
  output logic         load_fail,
  output logic [1:0]   fail_cause,
  output logic [3:0]   attempt_cnt,
  output logic [287:0] crc_latched,
  output logic [2:0]   seq_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GAP  = 3'd2,
    S_OK   = 3'd3,
    S_FAIL = 3'd4
  } state_e;

  localparam logic [3:0] MAX_RETRY_C = MAX_RETRY[3:0];

  state_e         state_q, state_d;
  logic [31:0]    tmo_q, tmo_d;
  logic [15:0]    gap_q, gap_d;
  logic [3:0]     att_q, att_d;
  logic [1:0]     cause_q, cause_d;
  logic [287:0]   crc_q, crc_d;
  logic           en_q, en_d;
  logic           busy_q, busy_d;
  logic           ok_q, ok_d;
  logic           fail_q, fail_d;
  logic           attempt_fail;

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    att_d        = att_q;
    cause_d      = cause_q;
    crc_d        = crc_q;
    attempt_fail = 1'b0;

    case (state_q)
      S_IDLE, S_OK, S_FAIL: begin
        if (init_start) begin
          att_d   = 4'd0;
          cause_d = 2'b00;
          tmo_d   = 32'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        // Error outranks done, and both outrank an expiring timeout.
        if (load_ram_error) begin
          cause_d      = 2'b01;
          attempt_fail = 1'b1;
        end else if (load_ram_done) begin
          crc_d   = load_ram_crc;
          state_d = S_OK;
        end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          cause_d      = 2'b10;
          attempt_fail = 1'b1;
        end
        if (attempt_fail) begin
          if (att_q < MAX_RETRY_C) begin
            gap_d   = 16'd0;
            att_d   = att_q + 4'd1;
            state_d = S_GAP;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == RETRY_GAP - 16'd1) begin
          tmo_d   = 32'd0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    en_d   = (state_d == S_WAIT);
    busy_d = (state_d == S_WAIT) || (state_d == S_GAP);
    ok_d   = (state_d == S_OK);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge sys_clk) begin
    if (!glbl_rst_n) begin
      state_q <= S_IDLE;
      tmo_q   <= 32'd0;
      gap_q   <= 16'd0;
      att_q   <= 4'd0;
      cause_q <= 2'b00;
      crc_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      att_q   <= att_d;
      cause_q <= cause_d;
      crc_q   <= crc_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
    end
  end

  assign load_ram_en = en_q;
  assign load_busy   = busy_q;
  assign load_ok     = ok_q;
  assign load_fail   = fail_q;
  assign fail_cause  = cause_q;
  assign attempt_cnt = att_q;
  assign crc_latched = crc_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_init_load_seq.sv
// Bench for init_load_seq: emulated loader answers each attempt at a scripted offset.
module tb_init_load_seq;
  localparam int T = 100;
  localparam int R = 2;
  localparam int G = 8;

  logic         sys_clk = 1'b0;
  logic         glbl_rst_n = 1'b0;
  logic         init_start = 1'b0;
  logic         load_ram_done = 1'b0;
  logic         load_ram_error = 1'b0;
  logic [287:0] load_ram_crc = '0;
  logic         load_ram_en, load_busy, load_ok, load_fail;
  logic [1:0]   fail_cause;
  logic [3:0]   attempt_cnt;
  logic [287:0] crc_latched;
  logic [2:0]   seq_state;

  init_load_seq #(
    .TIMEOUT_CYCLES(32'd100),
    .MAX_RETRY(2),
    .RETRY_GAP(16'd8)
  ) dut (
    .sys_clk(sys_clk),
    .glbl_rst_n(glbl_rst_n),
    .init_start(init_start),
    .load_ram_en(load_ram_en),
    .load_ram_done(load_ram_done),
    .load_ram_error(load_ram_error),
    .load_ram_crc(load_ram_crc),
    .load_busy(load_busy),
    .load_ok(load_ok),
    .load_fail(load_fail),
    .fail_cause(fail_cause),
    .attempt_cnt(attempt_cnt),
    .crc_latched(crc_latched),
    .seq_state(seq_state)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  logic [287:0] exp_crc = '0;

  // kinds per attempt: 0 no response, 1 done, 2 error, 3 done+error
  typedef struct {
    int k0, d0, k1, d1, k2, d2;
    bit ok;
    int cause;
    int att;
    int en_total;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_crc(input string nm, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " en"}, int'(load_ram_en), 0);
    chk({nm, " busy"}, int'(load_busy), 0);
    chk({nm, " ok"}, int'(load_ok), 0);
    chk({nm, " fail"}, int'(load_fail), 0);
    chk({nm, " cause"}, int'(fail_cause), 0);
    chk({nm, " att"}, int'(attempt_cnt), 0);
    chk({nm, " state"}, int'(seq_state), 0);
    chk_crc({nm, " crc"}, crc_latched, 288'd0);
  endtask

  task automatic run_case(input string nm, input vec_t v, output int en_total);
    int kk[3];
    int dd[3];
    int ew[3];
    int nwin, ecause, eatt, cur, gcur, a;
    bit eok, fin;
    int win[$];
    int gaps[$];
    logic [287:0] case_crc;

    kk = '{v.k0, v.k1, v.k2};
    dd = '{v.d0, v.d1, v.d2};
    ew = '{0, 0, 0};

    // Attempt-level outcome from the sequencing rules.
    eok = 1'b0; ecause = 0; nwin = 0; eatt = 0;
    for (int i = 0; i <= R; i++) begin
      if (!eok) begin
        nwin = i + 1;
        eatt = i;
        if (kk[i] == 0 || dd[i] >= T) begin
          ew[i] = T;
          ecause = 2;
        end else begin
          ew[i] = dd[i] + 1;
          if (kk[i] >= 2) ecause = 1;
          else eok = 1'b1;
        end
      end
    end

    for (int i = 0; i < 9; i++) case_crc[i*32 +: 32] = $urandom();

    @(negedge sys_clk);
    init_start = 1'b1;
    @(negedge sys_clk);
    init_start = 1'b0;
    chk({nm, " start en"}, int'(load_ram_en), 1);
    chk({nm, " start busy"}, int'(load_busy), 1);
    chk({nm, " start att"}, int'(attempt_cnt), 0);
    chk({nm, " start cause"}, int'(fail_cause), 0);

    cur = 0; gcur = 0; a = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 1500 && !fin; cyc++) begin
      load_ram_done = 1'b0;
      load_ram_error = 1'b0;
      init_start = 1'b0;
      for (int i = 0; i < 9; i++) load_ram_crc[i*32 +: 32] = $urandom();
      if (!load_ram_en && cur > 0) begin
        win.push_back(cur);
        cur = 0;
        a++;
      end
      if (load_ok || load_fail) begin
        fin = 1'b1;
      end else if (load_ram_en) begin
        if (gcur > 0) begin
          gaps.push_back(gcur);
          gcur = 0;
        end
        if (a <= R && kk[a] != 0 && cur == dd[a]) begin
          load_ram_done = kk[a][0];
          load_ram_error = kk[a][1];
          if (kk[a][0]) load_ram_crc = case_crc;
        end else if ($urandom_range(7) == 0) begin
          init_start = 1'b1;
        end
        cur++;
      end else if (load_busy) begin
        gcur++;
        load_ram_done = 1'($urandom_range(1));
        load_ram_error = 1'($urandom_range(1));
      end
      if (!fin) @(negedge sys_clk);
    end
    load_ram_done = 1'b0;
    load_ram_error = 1'b0;
    init_start = 1'b0;

    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL %s bound: no terminal state within cycle budget", nm);
    end
    if (eok) exp_crc = case_crc;

    chk({nm, " windows"}, win.size(), nwin);
    for (int i = 0; i < nwin && i < win.size(); i++) chk({nm, " win len"}, win[i], ew[i]);
    chk({nm, " gaps"}, gaps.size(), nwin - 1);
    foreach (gaps[i]) chk({nm, " gap len"}, gaps[i], G);
    chk({nm, " ok"}, int'(load_ok), int'(eok));
    chk({nm, " fail"}, int'(load_fail), int'(!eok));
    chk({nm, " cause"}, int'(fail_cause), ecause);
    chk({nm, " att"}, int'(attempt_cnt), eatt);
    chk({nm, " state"}, int'(seq_state), eok ? 3 : 4);
    chk({nm, " busy"}, int'(load_busy), 0);
    chk_crc({nm, " crc"}, crc_latched, exp_crc);

    en_total = 0;
    foreach (win[i]) en_total += win[i];
  endtask

  vec_t tbl[7];

  initial begin
    int en_total;
    vec_t rv;

    tbl[0] = '{1, 19, 0, 0, 0, 0, 1'b1, 0, 0, 20};      // clean pass, en 20 cycles
    tbl[1] = '{2, 5, 1, 10, 0, 0, 1'b1, 1, 1, 17};      // error then pass
    tbl[2] = '{0, 0, 0, 0, 0, 0, 1'b0, 2, 2, 300};      // all timeouts
    tbl[3] = '{0, 0, 0, 0, 3, 3, 1'b0, 1, 2, 204};      // done+error on final attempt
    tbl[4] = '{1, 99, 0, 0, 0, 0, 1'b1, 0, 0, 100};     // done on the timeout cycle
    tbl[5] = '{2, 0, 0, 0, 1, 0, 1'b1, 2, 2, 102};      // error, timeout, pass
    tbl[6] = '{2, 2, 2, 2, 2, 2, 1'b0, 1, 2, 9};        // errors exhaust retries

    glbl_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_reset("reset");
    glbl_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_case($sformatf("vec%0d", i), tbl[i], en_total);
      chk($sformatf("vec%0d tbl ok", i), int'(load_ok), int'(tbl[i].ok));
      chk($sformatf("vec%0d tbl cause", i), int'(fail_cause), tbl[i].cause);
      chk($sformatf("vec%0d tbl att", i), int'(attempt_cnt), tbl[i].att);
      chk($sformatf("vec%0d tbl en_total", i), en_total, tbl[i].en_total);
    end

    // Reset while waiting on the loader.
    @(negedge sys_clk);
    init_start = 1'b1;
    @(negedge sys_clk);
    init_start = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("midwait en", int'(load_ram_en), 1);
    glbl_rst_n = 1'b0;
    @(negedge sys_clk);
    chk_reset("midwait reset");
    glbl_rst_n = 1'b1;
    exp_crc = '0;

    for (int n = 0; n < 25; n++) begin
      rv.k0 = $urandom_range(3);
      rv.k1 = $urandom_range(3);
      rv.k2 = $urandom_range(3);
      rv.d0 = ($urandom_range(3) == 0) ? $urandom_range(T + 5, T - 2) : $urandom_range(40);
      rv.d1 = ($urandom_range(3) == 0) ? $urandom_range(T + 5, T - 2) : $urandom_range(40);
      rv.d2 = ($urandom_range(3) == 0) ? $urandom_range(T + 5, T - 2) : $urandom_range(40);
      rv.ok = 1'b0; rv.cause = 0; rv.att = 0; rv.en_total = 0;
      run_case($sformatf("rnd%0d", n), rv, en_total);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
